// File: rtl/pet_status_engine.sv
// Pet activity state machine and saturating food/joy/energy counters
// feeding the LCD status display; all outputs are registered.
module pet_status_engine #(
    parameter int MAX_VALUE     = 5,
    parameter int NUM_FACES     = 9,
    parameter int FOOD_DECAY    = 10,
    parameter int JOY_DECAY     = 8,
    parameter int ENERGY_DECAY  = 12,
    parameter int SLEEP_RECOVER = 4,
    parameter int ANIM_TICKS    = 3,
    parameter int STARVE_TICKS  = 20,
    localparam int FW = $clog2(NUM_FACES),
    localparam int SW = $clog2(MAX_VALUE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          btn_feed,
    input  logic          btn_play,
    input  logic          btn_sleep,
    output logic [FW-1:0] face,
    output logic [SW-1:0] food_value,
    output logic [SW-1:0] joy_value,
    output logic [SW-1:0] energy_value,
    output logic          pet_dead
);

    localparam int CW = 8;
    localparam int WW = SW + 2;

    localparam logic [SW-1:0] MAXV = SW'(MAX_VALUE);
    localparam logic [SW-1:0] HIV  = SW'(MAX_VALUE - 1);
    localparam logic [SW-1:0] LOWV = SW'(1);
    localparam logic signed [WW-1:0] MAXW = WW'(MAX_VALUE);

    localparam logic [CW-1:0] FOOD_L   = CW'(FOOD_DECAY - 1);
    localparam logic [CW-1:0] JOY_L    = CW'(JOY_DECAY - 1);
    localparam logic [CW-1:0] ENERGY_L = CW'(ENERGY_DECAY - 1);
    localparam logic [CW-1:0] RECOV_L  = CW'(SLEEP_RECOVER - 1);
    localparam logic [CW-1:0] ANIM_L   = CW'(ANIM_TICKS - 1);
    localparam logic [CW-1:0] STARVE_P = CW'(STARVE_TICKS);

    localparam logic [FW-1:0] F_HAPPY   = FW'(0);
    localparam logic [FW-1:0] F_NEUTRAL = FW'(1);
    localparam logic [FW-1:0] F_SAD     = FW'(2);
    localparam logic [FW-1:0] F_HUNGRY  = FW'(3);
    localparam logic [FW-1:0] F_TIRED   = FW'(4);
    localparam logic [FW-1:0] F_EATING  = FW'(5);
    localparam logic [FW-1:0] F_PLAYING = FW'(6);
    localparam logic [FW-1:0] F_SLEEP   = FW'(7);
    localparam logic [FW-1:0] F_DEAD    = FW'(8);

    typedef enum logic [2:0] {
        S_AWAKE, S_EATING, S_PLAYING, S_SLEEPING, S_DEAD
    } state_t;

    state_t state, state_n;
    logic [SW-1:0] food, joy, energy;
    logic [SW-1:0] food_n, joy_n, energy_n;
    logic [CW-1:0] food_cnt, joy_cnt, energy_cnt, recov_cnt, anim_cnt, starve_cnt;
    logic [CW-1:0] food_cnt_n, joy_cnt_n, energy_cnt_n, recov_cnt_n, anim_cnt_n, starve_cnt_n;
    logic food_hit, joy_hit, energy_hit, recov_hit, anim_hit;
    logic awake, sleeping, animating;
    logic act_sleep, act_feed, act_play;
    logic [FW-1:0] face_c;
    logic signed [WW-1:0] food_w, joy_w, energy_w;

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c,
                                               input logic en,
                                               input logic hit);
        if (!en)
            return c;
        return hit ? '0 : c + CW'(1);
    endfunction

    function automatic logic [SW-1:0] clamp(input logic signed [WW-1:0] v);
        if (v < 0)
            return '0;
        if (v > MAXW)
            return MAXV;
        return v[SW-1:0];
    endfunction

    assign food_value   = food;
    assign joy_value    = joy;
    assign energy_value = energy;

    always_comb begin
        awake     = (state == S_AWAKE);
        sleeping  = (state == S_SLEEPING);
        animating = (state == S_EATING) || (state == S_PLAYING);

        act_sleep = awake && btn_sleep;
        act_feed  = awake && btn_feed && !btn_sleep;
        act_play  = awake && btn_play && !btn_sleep && !btn_feed && (energy != '0);

        food_hit   = tick && (awake || sleeping) && (food_cnt == FOOD_L);
        joy_hit    = tick && awake && (joy_cnt == JOY_L);
        energy_hit = tick && awake && (energy_cnt == ENERGY_L);
        recov_hit  = tick && sleeping && (recov_cnt == RECOV_L);
        anim_hit   = tick && animating && (anim_cnt == ANIM_L);

        food_cnt_n   = next_cnt(food_cnt, tick && (awake || sleeping), food_hit);
        joy_cnt_n    = next_cnt(joy_cnt, tick && awake, joy_hit);
        energy_cnt_n = next_cnt(energy_cnt, tick && awake, energy_hit);
        recov_cnt_n  = next_cnt(recov_cnt, tick && sleeping, recov_hit);
        anim_cnt_n   = next_cnt(anim_cnt, tick && animating, anim_hit);

        // Decay and button gain merge in one wider sum before clamping
        food_w   = WW'(food) - WW'(food_hit) + (act_feed ? WW'(2) : WW'(0));
        joy_w    = WW'(joy) - WW'(joy_hit) + WW'(act_play);
        energy_w = WW'(energy) - WW'(energy_hit) - WW'(act_play) + WW'(recov_hit);
        food_n   = clamp(food_w);
        joy_n    = clamp(joy_w);
        energy_n = clamp(energy_w);

        starve_cnt_n = starve_cnt;
        if (food != '0)
            starve_cnt_n = '0;
        else if (tick)
            starve_cnt_n = starve_cnt + CW'(1);

        state_n = state;
        unique case (state)
            S_AWAKE: begin
                if (act_sleep)
                    state_n = S_SLEEPING;
                else if (act_feed)
                    state_n = S_EATING;
                else if (act_play)
                    state_n = S_PLAYING;
            end
            S_EATING, S_PLAYING: begin
                if (anim_hit)
                    state_n = S_AWAKE;
            end
            S_SLEEPING: begin
                if (btn_sleep || (tick && energy_n == MAXV))
                    state_n = S_AWAKE;
            end
            default: state_n = S_DEAD;
        endcase
        if (starve_cnt_n >= STARVE_P)
            state_n = S_DEAD;

        face_c = F_NEUTRAL;
        unique case (state)
            S_DEAD:     face_c = F_DEAD;
            S_SLEEPING: face_c = F_SLEEP;
            S_PLAYING:  face_c = F_PLAYING;
            S_EATING:   face_c = F_EATING;
            default: begin
                if (food <= LOWV)
                    face_c = F_HUNGRY;
                else if (energy <= LOWV)
                    face_c = F_TIRED;
                else if (joy <= LOWV)
                    face_c = F_SAD;
                else if (food >= HIV && joy >= HIV && energy >= HIV)
                    face_c = F_HAPPY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_AWAKE;
            food       <= MAXV;
            joy        <= MAXV;
            energy     <= MAXV;
            food_cnt   <= '0;
            joy_cnt    <= '0;
            energy_cnt <= '0;
            recov_cnt  <= '0;
            anim_cnt   <= '0;
            starve_cnt <= '0;
            face       <= F_HAPPY;
            pet_dead   <= 1'b0;
        end else begin
            face     <= face_c;
            pet_dead <= (state == S_DEAD);
            // DEAD freezes every stat and counter
            if (state != S_DEAD) begin
                state      <= state_n;
                food       <= food_n;
                joy        <= joy_n;
                energy     <= energy_n;
                food_cnt   <= food_cnt_n;
                joy_cnt    <= joy_cnt_n;
                energy_cnt <= energy_cnt_n;
                recov_cnt  <= recov_cnt_n;
                anim_cnt   <= anim_cnt_n;
                starve_cnt <= starve_cnt_n;
            end
        end
    end

endmodule
